spi_tx_shifter: RTL and testbench

SPI_TX_SHIFTER -- requirements
Module: spi_tx_shifter

---
 rtl/spi_pkg.sv | 14 +
 rtl/dff.sv | 17 +
 rtl/spi_bit_cnt.sv | 29 ++
 rtl/spi_tx_shifter.sv | 113 +++++++++++
 tb/tb_spi_tx_shifter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and length decode for the SPI transmit shifter
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_tx_state_e;

  // A zero length field encodes a full-width character.
  function automatic int unsigned spi_eff_len(input int unsigned len, input int unsigned data_w);
    return (len == 0) ? data_w : len;
  endfunction

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - resettable D flip-flop cell with configurable reset value
module dff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= RESET_VALUE;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/spi_bit_cnt.sv
// rtl/spi_bit_cnt.sv - remaining-bits counter for the SPI transmit shifter
module spi_bit_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  // Holds remaining-1 so a full DATA_W-bit character still fits in CNT_W bits.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - SPI MOSI character serialiser with IDLE/SHIFT control
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int   DATA_W    = 32,
  parameter int   CNT_W     = $clog2(DATA_W),
  parameter logic IDLE_VAL  = 1'b1,
  parameter bit   HOLD_LAST = 1'b1
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  char_len,
  input  logic              lsb,
  input  logic              shift_en,
  input  logic              abort,
  output logic              mosi_pad_o,
  output logic              busy,
  output logic              done
);

  localparam int LEN_W = CNT_W + 1;

  spi_tx_state_e     state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              lsb_q, lsb_d;
  logic              mosi_d;
  logic              cnt_load, cnt_dec, cnt_last;
  logic [LEN_W-1:0]  len_eff, pad_bits;
  logic [CNT_W-1:0]  cnt_init;
  logic [DATA_W-1:0] aligned;
  logic              accept;

  assign len_eff  = LEN_W'(spi_eff_len(32'(char_len), DATA_W));
  assign cnt_init = CNT_W'(len_eff - LEN_W'(1));
  assign pad_bits = LEN_W'(DATA_W) - len_eff;
  // MSB-first characters are left-aligned so the send bit is always sr[DATA_W-1].
  assign aligned  = lsb ? load_data : (load_data << pad_bits);

  assign load_ready = (state_q == IDLE) && !abort;
  assign busy       = (state_q == SHIFT);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    lsb_d    = lsb_q;
    mosi_d   = mosi_pad_o;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!HOLD_LAST) mosi_d = IDLE_VAL;
        if (accept) begin
          state_d  = SHIFT;
          sr_d     = aligned;
          lsb_d    = lsb;
          mosi_d   = lsb ? aligned[0] : aligned[DATA_W-1];
          cnt_load = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          mosi_d  = IDLE_VAL;
        end else if (shift_en) begin
          if (cnt_last) begin
            state_d = IDLE;
            done    = 1'b1;
            if (!HOLD_LAST) mosi_d = IDLE_VAL;
          end else begin
            cnt_dec = 1'b1;
            sr_d    = lsb_q ? (sr_q >> 1) : (sr_q << 1);
            mosi_d  = lsb_q ? sr_q[1] : sr_q[DATA_W-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      lsb_q   <= lsb_d;
    end
  end

  spi_bit_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk_i      (pclk),
    .rst_ni     (presetn),
    .load_i     (cnt_load),
    .load_val_i (cnt_init),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  dff #(.WIDTH(1), .RESET_VALUE(IDLE_VAL)) u_mosi_ff (
    .clk_i  (pclk),
    .rst_ni (presetn),
    .d_i    (mosi_d),
    .q_o    (mosi_pad_o)
  );

endmodule

// File: tb/tb_spi_tx_shifter.sv
// tb/tb_spi_tx_shifter.sv - self-checking bench for spi_tx_shifter
module tb_spi_tx_shifter;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       load_valid, lsb, shift_en, abort;
  logic [7:0] load_data;
  logic [2:0] char_len;
  logic       ready_a, busy_a, done_a, mosi_a;
  logic       ready_b, busy_b, done_b, mosi_b;

  int total  = 0;
  int passed = 0;
  bit exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [2:0] len;
    logic       lsb;
    logic [7:0] seq;
  } vec_t;
  vec_t vecs[9];

  always #5 pclk = ~pclk;

  spi_tx_shifter #(.DATA_W(8)) dut_a (
    .pclk(pclk), .presetn(presetn), .load_valid(load_valid), .load_ready(ready_a),
    .load_data(load_data), .char_len(char_len), .lsb(lsb), .shift_en(shift_en),
    .abort(abort), .mosi_pad_o(mosi_a), .busy(busy_a), .done(done_a)
  );

  spi_tx_shifter #(.DATA_W(8), .IDLE_VAL(1'b0), .HOLD_LAST(1'b0)) dut_b (
    .pclk(pclk), .presetn(presetn), .load_valid(load_valid), .load_ready(ready_b),
    .load_data(load_data), .char_len(char_len), .lsb(lsb), .shift_en(shift_en),
    .abort(abort), .mosi_pad_o(mosi_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pop_check(input string name);
    bit b;
    if (exp_q.size() == 0) begin
      check({name, " scoreboard empty"}, 1, 0);
    end else begin
      b = exp_q.pop_front();
      check({name, " mosi_a"}, int'(mosi_a), int'(b));
      check({name, " mosi_b"}, int'(mosi_b), int'(b));
    end
  endtask

  task automatic accept_char(input logic [7:0] d, input logic [2:0] len, input logic l,
                             input logic [7:0] seq, input logic se, input string name);
    int n;
    n = (len == 0) ? 8 : int'(len);
    load_data  = d;
    char_len   = len;
    lsb        = l;
    load_valid = 1'b1;
    shift_en   = se;
    #1;
    check({name, " ready before accept"}, int'(ready_a), 1);
    tick();
    load_valid = 1'b0;
    shift_en   = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    pop_check({name, " first bit"});
    check({name, " busy after accept"}, int'(busy_a), 1);
  endtask

  task automatic shift_bits(input int cnt, input bit gap, input string name);
    for (int k = 0; k < cnt; k++) begin
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      pop_check($sformatf("%s bit%0d", name, k + 1));
      if (gap) tick();
    end
  endtask

  task automatic finish_char(input logic last, input string name);
    shift_en = 1'b1;
    #1;
    check({name, " done pulse"}, int'(done_a), 1);
    check({name, " done pulse b"}, int'(done_b), 1);
    check({name, " mosi_b held on done"}, int'(mosi_b), int'(last));
    tick();
    shift_en = 1'b0;
    check({name, " done cleared"}, int'(done_a), 0);
    check({name, " busy cleared"}, int'(busy_a), 0);
    check({name, " mosi_a holds last"}, int'(mosi_a), int'(last));
    check({name, " mosi_b idle"}, int'(mosi_b), 0);
    check({name, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 3'd0, 1'b0, 8'hA5};
    vecs[1] = '{8'h16, 3'd5, 1'b1, 8'h16};
    vecs[2] = '{8'h3C, 3'd6, 1'b0, 8'h0F};
    vecs[3] = '{8'hFE, 3'd1, 1'b0, 8'h00};
    vecs[4] = '{8'h01, 3'd1, 1'b1, 8'h01};
    vecs[5] = '{8'hC3, 3'd0, 1'b1, 8'hC3};
    vecs[6] = '{8'h01, 3'd0, 1'b0, 8'h80};
    vecs[7] = '{8'h0D, 3'd4, 1'b0, 8'h0B};
    vecs[8] = '{8'hF6, 3'd5, 1'b1, 8'h16};

    presetn    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    char_len   = '0;
    lsb        = 1'b0;
    shift_en   = 1'b0;
    abort      = 1'b0;
    tick();
    tick();
    check("reset mosi_a", int'(mosi_a), 1);
    check("reset mosi_b", int'(mosi_b), 0);
    check("reset busy", int'(busy_a), 0);
    check("reset done", int'(done_a), 0);
    presetn = 1'b1;
    #1;
    check("reset ready", int'(ready_a), 1);

    for (int i = 0; i < 9; i++) begin
      int n;
      string nm;
      n  = (vecs[i].len == 0) ? 8 : int'(vecs[i].len);
      nm = $sformatf("vec%0d", i);
      accept_char(vecs[i].data, vecs[i].len, vecs[i].lsb, vecs[i].seq, logic'(i == 0), nm);
      shift_bits(n - 1, bit'(i % 2), nm);
      finish_char(vecs[i].seq[n-1], nm);
      tick();
    end

    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    check("idle shift_en busy", int'(busy_a), 0);
    check("idle shift_en mosi", int'(mosi_a), 1);

    load_data  = 8'h81;
    char_len   = 3'd0;
    lsb        = 1'b0;
    load_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'(8'h81 >> i));
    pop_check("b2b first");
    load_data = 8'h7E;
    shift_bits(7, 1'b0, "b2b first");
    shift_en = 1'b1;
    #1;
    check("b2b done", int'(done_a), 1);
    check("b2b no ready on done", int'(ready_a), 0);
    tick();
    shift_en = 1'b0;
    check("b2b ready after done", int'(ready_a), 1);
    check("b2b idle gap", int'(busy_a), 0);
    tick();
    load_valid = 1'b0;
    check("b2b second accepted", int'(busy_a), 1);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'(8'h7E >> (7 - i)));
    pop_check("b2b second");
    shift_bits(7, 1'b0, "b2b second");
    finish_char(1'b0, "b2b second");
    tick();

    for (int j = 0; j < 2; j++) begin
      logic [7:0] d;
      d = (j == 0) ? 8'hFF : 8'h00;
      accept_char(d, 3'd0, 1'b0, d, 1'b0, $sformatf("abort%0d", j));
      shift_bits(2, 1'b0, $sformatf("abort%0d", j));
      shift_en = 1'b1;
      abort    = 1'b1;
      #1;
      check("abort no done", int'(done_a), 0);
      tick();
      shift_en = 1'b0;
      abort    = 1'b0;
      exp_q.delete();
      check("abort busy", int'(busy_a), 0);
      check("abort mosi_a", int'(mosi_a), 1);
      check("abort mosi_b", int'(mosi_b), 0);
      tick();
    end

    load_valid = 1'b1;
    abort      = 1'b1;
    #1;
    check("abort idle ready", int'(ready_a), 0);
    tick();
    load_valid = 1'b0;
    abort      = 1'b0;
    check("abort idle no accept", int'(busy_a), 0);

    accept_char(8'h00, 3'd0, 1'b0, 8'h00, 1'b0, "rst");
    shift_bits(1, 1'b0, "rst");
    #2;
    presetn = 1'b0;
    #1;
    check("rst async mosi_a", int'(mosi_a), 1);
    check("rst async busy", int'(busy_a), 0);
    check("rst async done", int'(done_a), 0);
    exp_q.delete();
    tick();
    presetn = 1'b1;
    #1;
    check("rst release ready", int'(ready_a), 1);
    tick();
    check("rst no done", int'(done_a), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
